// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared types for the register-file write-back arbiter.
//            XLEN      - RF write data width
//            wb_req_t  - one buffered RF write {destination, data}
//            wb_src_e  - which source wins the write port in a cycle
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [4:0]      rd_a;
    logic [XLEN-1:0] rd_d;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LSU  = 2'd1,
    SRC_EXE  = 2'd2
  } wb_src_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/u_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : u_wb_fifo
// Purpose  : DEPTH-entry FIFO of pending EXE register-file writes. Besides
//            the usual head/full/empty view it exports a per-entry valid bit
//            and destination register so the arbiter can compare every
//            buffered write against LSU and issue-side register numbers.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            push_i, din_i  - enqueue (caller guarantees !full_o)
//            pop_i          - dequeue head (caller guarantees !empty_o)
//            dout_o         - head entry
//            full_o/empty_o - occupancy flags
//            ent_vld_o      - valid bit per storage slot
//            ent_rd_o       - destination register per storage slot
// Revision : 1.0 - initial release
// ============================================================================
module u_wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_req_t               din_i,
  input  logic                  pop_i,
  output wb_req_t               dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH-1:0]      ent_vld_o,
  output logic [DEPTH-1:0][4:0] ent_rd_o
);

  localparam int             PW     = $clog2(DEPTH);
  localparam logic [PW:0]    C_FULL = (PW+1)'(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      cnt_q;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      // Push and pop never target the same slot: that would need the FIFO
      // to be both non-full and non-empty with equal pointers.
      if (pop_i) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o    = mem_q[rd_ptr_q];
  assign full_o    = (cnt_q == C_FULL);
  assign empty_o   = (cnt_q == '0);
  assign ent_vld_o = vld_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_rd_o[i] = mem_q[i].rd_a;
  end

endmodule : u_wb_fifo
`default_nettype wire

// File: rtl/u_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : u_wb_arb
// Purpose  : Register-file write-port arbiter between EXE results (buffered
//            in a small FIFO) and LSU load returns (served directly). One
//            registered RF write per cycle; a starvation counter bounds how
//            long buffered EXE writes wait behind the LSU.
// Ports    : clk, rst                  - clock, sync active-high reset
//            exe_valid/exe_ready       - EXE write handshake
//            exe_rd_a/exe_rd_d         - EXE destination / data
//            lsu_valid/lsu_ready       - LSU write handshake (ready = grant)
//            lsu_rd_a/lsu_rd_d         - LSU destination / data
//            rs1_a/rs2_a, hazard       - issue-side buffered-write query
//            rf_rd_e/rf_rd_a/rf_rd_i   - registered RF write port
//            busy                      - FIFO non-empty or write in flight
// Notes    : XLEN must match wb_pkg::XLEN (the buffered entry type).
// Revision : 1.0 - initial release
// ============================================================================
module u_wb_arb
  import wb_pkg::*;
#(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exe_valid,
  output logic            exe_ready,
  input  logic [4:0]      exe_rd_a,
  input  logic [XLEN-1:0] exe_rd_d,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd_a,
  input  logic [XLEN-1:0] lsu_rd_d,
  input  logic [4:0]      rs1_a,
  input  logic [4:0]      rs2_a,
  output logic            hazard,
  output logic            rf_rd_e,
  output logic [4:0]      rf_rd_a,
  output logic [XLEN-1:0] rf_rd_i,
  output logic            busy
);

  localparam int             SW           = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  C_STARVE_MAX = SW'(STARVE_MAX);

  // --------------------------------------------------------------------------
  // EXE FIFO
  // --------------------------------------------------------------------------
  wb_req_t                w_push_req;
  wb_req_t                w_head;
  logic                   w_push;
  logic                   w_full;
  logic                   w_empty;
  logic [DEPTH-1:0]       w_ent_vld;
  logic [DEPTH-1:0][4:0]  w_ent_rd;
  logic                   w_grant_lsu;
  logic                   w_grant_fifo;

  assign w_push_req.rd_a = exe_rd_a;
  assign w_push_req.rd_d = exe_rd_d;

  u_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (w_push),
    .din_i     (w_push_req),
    .pop_i     (w_grant_fifo),
    .dout_o    (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .ent_vld_o (w_ent_vld),
    .ent_rd_o  (w_ent_rd)
  );

  // Ready ignores a same-cycle pop so the push decision never depends on
  // the grant path.
  assign exe_ready = !rst && !w_full;
  assign w_push    = exe_valid && exe_ready;

  // --------------------------------------------------------------------------
  // Buffered-write compares (LSU WAW block and issue hazard)
  // --------------------------------------------------------------------------
  logic w_lsu_hit;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_lsu_blk;

  always_comb begin
    w_lsu_hit = 1'b0;
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_rd[i] == lsu_rd_a)) w_lsu_hit = 1'b1;
      if (w_ent_vld[i] && (w_ent_rd[i] == rs1_a))    w_rs1_hit = 1'b1;
      if (w_ent_vld[i] && (w_ent_rd[i] == rs2_a))    w_rs2_hit = 1'b1;
    end
  end

  // An LSU write to a register with an older buffered EXE write must wait,
  // otherwise the older value would land last.
  assign w_lsu_blk = (lsu_rd_a != 5'd0) && w_lsu_hit;
  assign hazard    = ((rs1_a != 5'd0) && w_rs1_hit) ||
                     ((rs2_a != 5'd0) && w_rs2_hit);

  // --------------------------------------------------------------------------
  // Grant and starvation counter
  // --------------------------------------------------------------------------
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  wb_src_e       w_src;

  assign w_grant_lsu  = !rst && lsu_valid && !w_lsu_blk &&
                        (w_empty || (starve_q < C_STARVE_MAX));
  assign w_grant_fifo = !rst && !w_empty && !w_grant_lsu;
  assign lsu_ready    = w_grant_lsu;

  always_comb begin
    w_src = SRC_NONE;
    if (w_grant_lsu)       w_src = SRC_LSU;
    else if (w_grant_fifo) w_src = SRC_EXE;
  end

  // Only LSU grants taken while EXE work is waiting count as starvation.
  always_comb begin
    starve_d = starve_q;
    if (w_empty || w_grant_fifo)
      starve_d = '0;
    else if (w_grant_lsu && (starve_q < C_STARVE_MAX))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  // --------------------------------------------------------------------------
  // Registered RF write port
  // --------------------------------------------------------------------------
  logic            rf_e_q, rf_e_d;
  logic [4:0]      rf_a_q, rf_a_d;
  logic [XLEN-1:0] rf_d_q, rf_d_d;

  // Writes to x0 are consumed but never enable the port; address/data hold
  // whenever nothing is written.
  always_comb begin
    rf_e_d = 1'b0;
    rf_a_d = rf_a_q;
    rf_d_d = rf_d_q;
    case (w_src)
      SRC_LSU: begin
        if (lsu_rd_a != 5'd0) begin
          rf_e_d = 1'b1;
          rf_a_d = lsu_rd_a;
          rf_d_d = lsu_rd_d;
        end
      end
      SRC_EXE: begin
        if (w_head.rd_a != 5'd0) begin
          rf_e_d = 1'b1;
          rf_a_d = w_head.rd_a;
          rf_d_d = w_head.rd_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_e_q <= 1'b0;
      rf_a_q <= '0;
      rf_d_q <= '0;
    end else begin
      rf_e_q <= rf_e_d;
      rf_a_q <= rf_a_d;
      rf_d_q <= rf_d_d;
    end
  end

  assign rf_rd_e = rf_e_q;
  assign rf_rd_a = rf_a_q;
  assign rf_rd_i = rf_d_q;
  assign busy    = !w_empty || rf_e_q;

endmodule : u_wb_arb
`default_nettype wire

// File: tb/tb_u_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_u_wb_arb
// Purpose  : Self-checking bench for u_wb_arb. Directed stimulus pushes the
//            hand-derived order of RF writes into a queue; an independent
//            monitor pops and compares every cycle rf_rd_e is high.
//            Handshake, hazard and busy outputs are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_u_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid, exe_ready;
  logic [4:0]  exe_rd_a;
  logic [31:0] exe_rd_d;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd_a;
  logic [31:0] lsu_rd_d;
  logic [4:0]  rs1_a, rs2_a;
  logic        hazard;
  logic        rf_rd_e;
  logic [4:0]  rf_rd_a;
  logic [31:0] rf_rd_i;
  logic        busy;

  always #5 clk = ~clk;

  u_wb_arb #(.XLEN(32), .DEPTH(2), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .exe_valid (exe_valid),
    .exe_ready (exe_ready),
    .exe_rd_a  (exe_rd_a),
    .exe_rd_d  (exe_rd_d),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd_a  (lsu_rd_a),
    .lsu_rd_d  (lsu_rd_d),
    .rs1_a     (rs1_a),
    .rs2_a     (rs2_a),
    .hazard    (hazard),
    .rf_rd_e   (rf_rd_e),
    .rf_rd_a   (rf_rd_a),
    .rf_rd_i   (rf_rd_i),
    .busy      (busy)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every RF write must match the next expected write.
  always @(negedge clk) begin
    exp_t e;
    if (rf_rd_e === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d d=0x%0h, expected no write at %0t",
                 rf_rd_a, rf_rd_i, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", {27'd0, rf_rd_a}, {27'd0, e.a});
        chk("wb_data", rf_rd_i, e.d);
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic ngd;
    @(negedge clk);
  endtask

  task automatic idle_in;
    exe_valid = 1'b0; exe_rd_a = 5'd0; exe_rd_d = 32'd0;
    lsu_valid = 1'b0; lsu_rd_a = 5'd0; lsu_rd_d = 32'd0;
    rs1_a = 5'd0; rs2_a = 5'd0;
  endtask

  task automatic exe(input logic [4:0] rd, input logic [31:0] d);
    exe_valid = 1'b1; exe_rd_a = rd; exe_rd_d = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = 1'b1; lsu_rd_a = rd; lsu_rd_d = d;
  endtask

  task automatic expw(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back('{a: rd, d: d});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_in();
    lsu(5'd1, 32'h1);
    exe(5'd1, 32'h1);
    // ---- reset state ----
    ngd();
    chk("rst_exe_ready", {31'd0, exe_ready}, 32'd0);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    nxt();
    idle_in();
    nxt();
    rst = 1'b0;
    ngd();
    chk("rst_rf_e", {31'd0, rf_rd_e}, 32'd0);
    chk("rst_rf_a", {27'd0, rf_rd_a}, 32'd0);
    chk("rst_rf_d", rf_rd_i, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_exe_ready", {31'd0, exe_ready}, 32'd1);
    nxt();

    // ---- single EXE write, latency and busy ----
    exe(5'd5, 32'h1234);
    expw(5'd5, 32'h1234);
    ngd();
    nxt();
    idle_in();
    ngd();
    chk("t1_busy_buffered", {31'd0, busy}, 32'd1);
    chk("t1_rf_e_early", {31'd0, rf_rd_e}, 32'd0);
    nxt();
    ngd();
    chk("t1_rf_e", {31'd0, rf_rd_e}, 32'd1);
    chk("t1_busy_write", {31'd0, busy}, 32'd1);
    nxt();
    ngd();
    chk("t1_busy_drop", {31'd0, busy}, 32'd0);
    nxt();

    // ---- simultaneous EXE rd3 and LSU rd7 on empty FIFO ----
    exe(5'd3, 32'h3333);
    lsu(5'd7, 32'h7777);
    expw(5'd7, 32'h7777);
    expw(5'd3, 32'h3333);
    ngd();
    chk("t2_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    nxt();
    idle_in();
    repeat (3) nxt();

    // ---- WAW block: FIFO holds rd9, LSU rd9 waits ----
    exe(5'd9, 32'h9E9E);
    lsu(5'd4, 32'h4444);
    expw(5'd4, 32'h4444);
    expw(5'd9, 32'h9E9E);
    expw(5'd9, 32'h9D9D);
    ngd();
    chk("t3_lsu_ready_a", {31'd0, lsu_ready}, 32'd1);
    nxt();
    exe_valid = 1'b0;
    lsu(5'd9, 32'h9D9D);
    rs1_a = 5'd9;
    ngd();
    chk("t3_lsu_blocked", {31'd0, lsu_ready}, 32'd0);
    chk("t3_hazard", {31'd0, hazard}, 32'd1);
    nxt();
    rs1_a = 5'd0;
    ngd();
    chk("t3_lsu_ready_c", {31'd0, lsu_ready}, 32'd1);
    nxt();
    idle_in();
    repeat (3) nxt();

    // ---- starvation limit ----
    exe(5'd10, 32'hA0A0);
    lsu(5'd11, 32'hB000);
    expw(5'd11, 32'hB000);
    expw(5'd11, 32'hB001);
    expw(5'd11, 32'hB002);
    expw(5'd11, 32'hB003);
    expw(5'd10, 32'hA0A0);
    expw(5'd11, 32'hB004);
    ngd();
    chk("t4_lsu_ready_0", {31'd0, lsu_ready}, 32'd1);
    nxt();
    exe_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      lsu(5'd11, 32'hB000 + i);
      ngd();
      chk("t4_lsu_ready_n", {31'd0, lsu_ready}, 32'd1);
      nxt();
    end
    lsu(5'd11, 32'hB004);
    ngd();
    chk("t4_lsu_starved", {31'd0, lsu_ready}, 32'd0);
    nxt();
    ngd();
    chk("t4_lsu_resume", {31'd0, lsu_ready}, 32'd1);
    nxt();
    idle_in();
    repeat (3) nxt();

    // ---- fill FIFO, full ignores pop, hazard queries ----
    expw(5'd13, 32'hD001);
    expw(5'd13, 32'hD002);
    expw(5'd13, 32'hD003);
    expw(5'd13, 32'hD004);
    expw(5'd12, 32'hC012);
    expw(5'd13, 32'hD005);
    expw(5'd14, 32'hC014);
    expw(5'd15, 32'hC015);
    exe(5'd12, 32'hC012);
    lsu(5'd13, 32'hD001);
    ngd();
    nxt();
    exe(5'd14, 32'hC014);
    lsu(5'd13, 32'hD002);
    ngd();
    chk("t5_ready_one", {31'd0, exe_ready}, 32'd1);
    nxt();
    exe(5'd15, 32'hC015);
    lsu(5'd13, 32'hD003);
    rs1_a = 5'd12;
    ngd();
    chk("t5_full", {31'd0, exe_ready}, 32'd0);
    chk("t5_hazard_rs1", {31'd0, hazard}, 32'd1);
    nxt();
    lsu(5'd13, 32'hD004);
    rs1_a = 5'd0;
    ngd();
    chk("t5_hazard_x0", {31'd0, hazard}, 32'd0);
    nxt();
    lsu(5'd13, 32'hD005);
    rs2_a = 5'd14;
    ngd();
    chk("t5_full_draining", {31'd0, exe_ready}, 32'd0);
    chk("t5_lsu_starved", {31'd0, lsu_ready}, 32'd0);
    chk("t5_hazard_rs2", {31'd0, hazard}, 32'd1);
    nxt();
    rs2_a = 5'd0;
    ngd();
    chk("t5_ready_after_pop", {31'd0, exe_ready}, 32'd1);
    chk("t5_lsu_granted", {31'd0, lsu_ready}, 32'd1);
    nxt();
    idle_in();
    repeat (4) nxt();

    // ---- x0 write consumed silently ----
    exe(5'd0, 32'hDEAD);
    ngd();
    nxt();
    idle_in();
    ngd();
    chk("t6_busy_x0", {31'd0, busy}, 32'd1);
    nxt();
    ngd();
    chk("t6_x0_no_write", {31'd0, rf_rd_e}, 32'd0);
    chk("t6_busy_idle", {31'd0, busy}, 32'd0);
    nxt();

    // ---- reset with two buffered entries ----
    exe(5'd20, 32'h2020);
    lsu(5'd21, 32'h2106);
    expw(5'd21, 32'h2106);
    expw(5'd21, 32'h2107);
    ngd();
    nxt();
    exe(5'd22, 32'h2222);
    lsu(5'd21, 32'h2107);
    ngd();
    chk("t7_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    nxt();
    rst = 1'b1;
    exe(5'd23, 32'h2323);
    ngd();
    chk("t7_rst_exe_ready", {31'd0, exe_ready}, 32'd0);
    chk("t7_rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    nxt();
    rst = 1'b0;
    idle_in();
    rs1_a = 5'd20;
    rs2_a = 5'd22;
    ngd();
    chk("t7_no_write", {31'd0, rf_rd_e}, 32'd0);
    chk("t7_busy", {31'd0, busy}, 32'd0);
    chk("t7_hazard_cleared", {31'd0, hazard}, 32'd0);
    nxt();
    idle_in();
    ngd();
    chk("t7_no_drain", {31'd0, rf_rd_e}, 32'd0);
    nxt();

    repeat (3) nxt();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_u_wb_arb
`default_nettype wire
